sa_output_collector: RTL and testbench

Output-side collection stage placed directly after the output de-skew stage of the systolic array. Each cycle that the controller issues `CMD_STREAM` with `in_valid` high, it captures one de-skewed result row (`SA_SIZE` lanes of `ACTIVATION_SIZE` bits) into a small FIFO. It tags each row with its index within the output tile and a last-row flag. Rows leave through a valid/ready interface toward the writeback/memory side, and `full` gives the controller backpressure so it can hold off streaming.

---
 rtl/sa_output_collector.sv | 118 +++++++++++
 tb/tb_sa_output_collector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_output_collector.sv
// Systolic-array output collector: tags de-skewed result rows with their tile
// position and buffers them in a small FIFO toward the writeback side.
package GEMM_pkg;
  typedef enum logic [2:0] {
    CMD_IDLE         = 3'd0,
    CMD_LOAD_WEIGHTS = 3'd1,
    CMD_STREAM       = 3'd2,
    CMD_DRAIN        = 3'd3
  } command_t;
endpackage

module sa_output_collector
  import GEMM_pkg::*;
#(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int TILE_ROWS       = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ACTIVATION_SIZE-1:0]         rows_in [SA_SIZE],
  input  command_t                           cmd,
  input  logic                               in_valid,
  input  logic                               clear,
  output logic [ACTIVATION_SIZE-1:0]         out_data [SA_SIZE],
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(TILE_ROWS)-1:0]       out_row_idx,
  output logic                               out_last,
  output logic                               full,
  output logic [$clog2(FIFO_DEPTH):0]        count,
  output logic                               overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(TILE_ROWS);
  localparam int AW = ACTIVATION_SIZE;
  localparam int DW = SA_SIZE * AW;

  logic [DW-1:0] data_mem [FIFO_DEPTH];
  logic [RW-1:0] idx_mem  [FIFO_DEPTH];
  logic          last_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [RW-1:0] row_ctr_reg;
  logic          overflow_reg;

  logic          wr_req, wr_acc, pop, row_last;
  logic [DW-1:0] row_flat, head_flat;

  genvar gi;
  generate
    for (gi = 0; gi < SA_SIZE; gi++) begin : g_lane
      assign row_flat[gi*AW +: AW] = rows_in[gi];
      assign out_data[gi] = out_valid ? head_flat[gi*AW +: AW] : '0;
    end
  endgenerate

  assign wr_req   = (cmd == CMD_STREAM) && in_valid;
  assign pop      = out_valid && out_ready;
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign wr_acc   = wr_req && (!full || pop);
  assign row_last = (row_ctr_reg == RW'(TILE_ROWS - 1));

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !wr_acc)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      row_ctr_reg  <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      row_ctr_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg  <= wr_ptr_reg + 1'b1;
        row_ctr_reg <= row_last ? '0 : row_ctr_reg + 1'b1;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_req && !wr_acc)
        overflow_reg <= 1'b1;
      count_reg <= count_next;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc && !clear) begin
      data_mem[wr_ptr_reg] <= row_flat;
      idx_mem[wr_ptr_reg]  <= row_ctr_reg;
      last_mem[wr_ptr_reg] <= row_last;
    end
  end

  assign head_flat   = data_mem[rd_ptr_reg];
  assign out_valid   = (count_reg != '0);
  assign full        = (count_reg == CW'(FIFO_DEPTH));
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign out_row_idx = out_valid ? idx_mem[rd_ptr_reg] : '0;
  assign out_last    = out_valid ? last_mem[rd_ptr_reg] : 1'b0;

endmodule

// File: tb/tb_sa_output_collector.sv
// Directed checks of the output collector: streaming, backpressure, tile wrap,
// command filtering, clear and asynchronous reset.
module tb_sa_output_collector;
  import GEMM_pkg::*;

  localparam int SA = 8;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  rows_in [SA];
  command_t       cmd;
  logic           in_valid;
  logic           clear;
  logic [AW-1:0]  out_data [SA];
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_row_idx;
  logic           out_last;
  logic           full;
  logic [2:0]     count;
  logic           overflow;
  logic [SA*AW-1:0] out_flat;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sa_output_collector #(
    .SA_SIZE(SA), .ACTIVATION_SIZE(AW), .FIFO_DEPTH(4), .TILE_ROWS(8)
  ) dut (
    .clk(clk), .reset(reset), .rows_in(rows_in), .cmd(cmd),
    .in_valid(in_valid), .clear(clear), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx),
    .out_last(out_last), .full(full), .count(count), .overflow(overflow)
  );

  genvar gi;
  generate
    for (gi = 0; gi < SA; gi++) begin : g_flat
      assign out_flat[gi*AW +: AW] = out_data[gi];
    end
  endgenerate

  // Row r carries lane k = r*16+k.
  function automatic logic [SA*AW-1:0] exp_row(input int r);
    logic [SA*AW-1:0] f;
    for (int k = 0; k < SA; k++) f[k*AW +: AW] = AW'(r * 16 + k);
    return f;
  endfunction

  task automatic set_row(input int r);
    for (int k = 0; k < SA; k++) rows_in[k] = AW'(r * 16 + k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd = CMD_IDLE; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    set_row(0);
    step(); step();
    reset = 1'b0;
    step();
    n_vec++;
    if ({out_valid, full, overflow, out_last} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {out_valid, full, overflow, out_last});
    end
    n_vec++;
    if (count !== 3'd0 || out_row_idx !== 3'd0) begin
      n_bad++; $display("FAIL reset_count count=%0d idx=%0d want 0 0", count, out_row_idx);
    end
    n_vec++;
    if (out_flat !== '0) begin
      n_bad++; $display("FAIL reset_data got %h want 0", out_flat);
    end
    $display("reset: checked idle outputs");
  endtask

  // Stream n rows starting at tag t0 with out_ready high; idx starts at i0.
  task automatic stream_rows(input string name, input int t0, input int n, input int i0);
    out_ready = 1'b1; cmd = CMD_STREAM; in_valid = 1'b1;
    for (int r = 0; r < n; r++) begin
      int ei;
      ei = (i0 + r) % 8;
      set_row(t0 + r);
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_flat !== exp_row(t0 + r)) begin
        n_bad++; $display("FAIL %s_data row%0d valid=%b got %h want %h", name, r, out_valid, out_flat, exp_row(t0 + r));
      end
      n_vec++;
      if (out_row_idx !== 3'(ei) || out_last !== (ei == 7)) begin
        n_bad++; $display("FAIL %s_tag row%0d idx=%0d last=%b want %0d %b", name, r, out_row_idx, out_last, ei, ei == 7);
      end
      n_vec++;
      if (count !== 3'd1 || overflow !== 1'b0) begin
        n_bad++; $display("FAIL %s_count row%0d count=%0d ovf=%b want 1 0", name, r, count, overflow);
      end
      $display("%s: row %0d idx %0d last %b", name, r, out_row_idx, out_last);
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_bad++; $display("FAIL %s_drain valid=%b count=%0d want 0 0", name, out_valid, count);
    end
  endtask

  task automatic test_stream();
    stream_rows("stream", 0, 8, 0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; cmd = CMD_STREAM; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_row(20 + i);
      step();
      n_vec++;
      if (count !== 3'(i < 4 ? i + 1 : 4) || full !== (i >= 3) || overflow !== (i == 4)) begin
        n_bad++; $display("FAIL bp_fill req%0d count=%0d full=%b ovf=%b want %0d %b %b",
                          i, count, full, overflow, (i < 4 ? i + 1 : 4), i >= 3, i == 4);
      end
      $display("bp: write %0d count %0d full %b overflow %b", i, count, full, overflow);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (out_flat !== exp_row(20 + i) || out_row_idx !== 3'(i)) begin
        n_bad++; $display("FAIL bp_drain row%0d idx=%0d data=%h want %0d %h", i, out_row_idx, out_flat, i, exp_row(20 + i));
      end
      $display("bp: drain row %0d idx %0d", i, out_row_idx);
      step();
    end
    n_vec++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL bp_empty valid=%b ovf=%b want 0 1", out_valid, overflow);
    end
    out_ready = 1'b0; in_valid = 1'b1; set_row(30);
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_row_idx !== 3'd4 || out_flat !== exp_row(30)) begin
      n_bad++; $display("FAIL bp_next idx=%0d data=%h want 4 %h", out_row_idx, out_flat, exp_row(30));
    end
    $display("bp: next row idx %0d", out_row_idx);
    do_clear();
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0; cmd = CMD_STREAM; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_row(40 + i);
      step();
    end
    n_vec++;
    if (full !== 1'b1) begin
      n_bad++; $display("FAIL simul_full full=%b want 1", full);
    end
    out_ready = 1'b1; set_row(44);
    step();
    in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL simul_count count=%0d full=%b ovf=%b want 4 1 0", count, full, overflow);
    end
    $display("simul: count %0d overflow %b", count, overflow);
    for (int i = 1; i < 5; i++) begin
      n_vec++;
      if (out_flat !== exp_row(40 + i) || out_row_idx !== 3'(i)) begin
        n_bad++; $display("FAIL simul_order row%0d idx=%0d data=%h want %0d %h", i, out_row_idx, out_flat, i, exp_row(40 + i));
      end
      $display("simul: drain row %0d idx %0d", i, out_row_idx);
      step();
    end
    do_clear();
  endtask

  task automatic test_tile_wrap();
    stream_rows("wrap", 50, 10, 0);
  endtask

  task automatic test_filter();
    // Tile position is 2 after the 10-row wrap stream.
    out_ready = 1'b1; set_row(70);
    cmd = CMD_IDLE; in_valid = 1'b1;
    step();
    cmd = CMD_LOAD_WEIGHTS;
    step();
    cmd = CMD_STREAM; in_valid = 1'b0;
    step();
    n_vec++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL filter_nocap count=%0d valid=%b want 0 0", count, out_valid);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd1 || out_row_idx !== 3'd2 || out_flat !== exp_row(70)) begin
      n_bad++; $display("FAIL filter_ctr count=%0d idx=%0d want 1 2", count, out_row_idx);
    end
    $display("filter: count %0d idx %0d", count, out_row_idx);
    do_clear();
  endtask

  task automatic test_clear();
    out_ready = 1'b0; cmd = CMD_STREAM; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_row(80 + i);
      step();
    end
    n_vec++;
    if (count !== 3'd3) begin
      n_bad++; $display("FAIL clear_pre count=%0d want 3", count);
    end
    set_row(83); clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL clear_state count=%0d valid=%b ovf=%b want 0 0 0", count, out_valid, overflow);
    end
    in_valid = 1'b1; set_row(84);
    step();
    in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd1 || out_row_idx !== 3'd0 || out_flat !== exp_row(84)) begin
      n_bad++; $display("FAIL clear_after count=%0d idx=%0d data=%h want 1 0 %h", count, out_row_idx, out_flat, exp_row(84));
    end
    $display("clear: count %0d idx %0d", count, out_row_idx);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; cmd = CMD_STREAM; in_valid = 1'b1;
    set_row(90);
    step();
    in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd2) begin
      n_bad++; $display("FAIL areset_pre count=%0d want 2", count);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, full, overflow, out_last} !== 4'b0000 || count !== 3'd0 ||
        out_row_idx !== 3'd0 || out_flat !== '0) begin
      n_bad++; $display("FAIL areset_now valid=%b count=%0d idx=%0d data=%h want all 0",
                        out_valid, count, out_row_idx, out_flat);
    end
    $display("areset: count %0d valid %b", count, out_valid);
    step();
    reset = 1'b0;
    in_valid = 1'b1; set_row(91);
    step();
    in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd1 || out_row_idx !== 3'd0 || out_flat !== exp_row(91)) begin
      n_bad++; $display("FAIL areset_after count=%0d idx=%0d want 1 0", count, out_row_idx);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_simul();
    test_tile_wrap();
    test_filter();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
